mul_div_seq: RTL

MUL_DIV_SEQ -- requirements
Module: mul_div_seq

---
 rtl/mul_div_seq_pkg.sv | 31 +++
 rtl/mul_div_seq_alu.sv | 34 +++
 rtl/mul_div_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mul_div_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// FSM states, operation encoding and ALU control words.
package mul_div_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef struct packed {
    logic sr;
    logic ss;
    logic na;
    logic nb;
    logic xo;
    logic no;
    logic ic;
    logic ci;
  } alu_cw_t;

  localparam alu_cw_t CW_ADD = '{sr: 1'b0, ss: 1'b0, na: 1'b0, nb: 1'b0,
                                 xo: 1'b0, no: 1'b0, ic: 1'b0, ci: 1'b0};
  // Subtract is a + ~b + 1, so carry out high means no borrow.
  localparam alu_cw_t CW_SUB = '{sr: 1'b0, ss: 1'b0, na: 1'b0, nb: 1'b1,
                                 xo: 1'b0, no: 1'b0, ic: 1'b0, ci: 1'b1};

endpackage

// File: rtl/mul_div_seq_alu.sv
// Combinational ALU shared by the multiply and divide iterations:
// optional operand inversion, add or xor, optional shift right, output/carry inversion.
module mul_div_seq_alu
  import mul_div_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_cw_t      cw,
  output logic [W-1:0] out,
  output logic         cf
);

  logic [W-1:0] aa;
  logic [W-1:0] bb;
  logic [W:0]   pre;
  logic [W-1:0] shifted;

  always_comb begin
    aa = cw.na ? ~a : a;
    bb = cw.nb ? ~b : b;
    if (cw.xo) begin
      pre = {1'b0, aa ^ bb};
    end else begin
      pre = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cw.ci};
    end
    // ss selects an arithmetic shift by replicating the top bit.
    shifted = cw.sr ? {cw.ss & pre[W-1], pre[W-1:1]} : pre[W-1:0];
    out     = cw.no ? ~shifted : shifted;
    cf      = cw.sr ? pre[0] : (pre[W] ^ cw.ic);
  end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential 16-bit unsigned multiplier / divider: one shift-add or
// restoring-divide step per cycle through a single shared ALU.
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic         dz
);

  state_t       state_q, state_d;
  logic [3:0]   step_q, step_d;
  logic         op_q, op_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] m_q, m_d;
  logic         dz_q, dz_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [W-1:0] alu_a, alu_b, alu_out, rs;
  alu_cw_t      alu_cw;
  logic         alu_cf;

  mul_div_seq_alu #(.W(W)) u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .cw  (alu_cw),
    .out (alu_out),
    .cf  (alu_cf)
  );

  // hi/lo/m hold H/L/M for multiply and R/Q/D for divide.
  always_comb begin
    rs = {hi_q[W-2:0], lo_q[W-1]};
    if (op_q == OP_MUL) begin
      alu_a  = hi_q;
      alu_b  = lo_q[0] ? m_q : '0;
      alu_cw = CW_ADD;
    end else begin
      alu_a  = rs;
      alu_b  = m_q;
      alu_cw = CW_SUB;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          dz_d   = 1'b0;
          step_d = '0;
          hi_d   = '0;
          if (op == OP_DIV && opb == '0) begin
            state_d = S_DONE;
            dz_d    = 1'b1;
            hi_d    = opa;
            lo_d    = '1;
            m_d     = opb;
          end else begin
            state_d = S_RUN;
            lo_d    = (op == OP_MUL) ? opb : opa;
            m_d     = (op == OP_MUL) ? opa : opb;
          end
        end
      end
      S_RUN: begin
        if (op_q == OP_MUL) begin
          hi_d = {alu_cf, alu_out[W-1:1]};
          lo_d = {alu_out[0], lo_q[W-1:1]};
        end else if (hi_q[W-1] | alu_cf) begin
          hi_d = alu_out;
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = rs;
          lo_d = {lo_q[W-2:0], 1'b0};
        end
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      op_q    <= OP_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign res_hi = hi_q;
  assign res_lo = lo_q;
  assign dz     = dz_q;

endmodule
